write_back: RTL and testbench
=============================

// Module: write_back
// PURPOSE
//  Final pipeline stage. It sits directly downstream of the data-memory stage and consumes that stage's registered
//  64-bit dual-slot bundle (upper slot inst[63:32], lower slot inst[31:0]) plus the BRAM read word.
//  Per slot it selects load data or ALU result, resolves same-register collisions and registers the register-file
//  write ports. It also owns the HALT state machine and, optionally, retire counters.
// PARAMETERS
//  OP_LOAD   6'b010000        opcode (inst[31:26] per slot) selecting mem_doutb as write data
//  OP_HALT   6'b111111        opcode that stops retirement
//  CNT_W     32               retire-counter width (WB_RETIRE_CNT_EN only)
// PORTS
//  clk         in   1   clock, all state on posedge
//  rstn        in   1   asynchronous active-low reset
//  inst        in   64  bundle from memory stage; bubble = {3'b111,29'b0} per slot
//  u_rt        in   5   upper-slot destination register
//  u_rt_flag   in   1   upper slot writes a register
//  l_tdata     in   32  lower-slot ALU result (signed)
//  l_rt        in   5   lower-slot destination register
//  l_rt_flag   in   1   lower slot writes a register
//  mem_doutb   in   64  BRAM read data, aligned with inst: [63:32] upper, [31:0] lower
//  u_we/l_we   out  1   register-file write enables
//  u_waddr/l_waddr out 5    register-file write addresses
//  u_wdata/l_wdata out 32   register-file write data
//  fwd_u_*/fwd_l_* out 1/5/32  combinational bypass copies (we, addr, data) of this cycle's selected writes
//  halted      out  1   core stopped
//  retire_cnt  out  CNT_W  retired non-bubble slot count (WB_RETIRE_CNT_EN only)
// BEHAVIOUR
//  - Reset (async, rstn=0): all *_we=0, *_waddr=0, *_wdata=0, halted=0, state=RUN, retire_cnt=0.
//  - Slot valid = slot inst[31:29]!=3'b111 OR inst[28:0]!=0. Bubbles never write or count.
//  - Data select: slot opcode==OP_LOAD -> that slot's mem_doutb half; otherwise upper gets its mem half
//    (no ALU path on upper) and lower gets l_tdata.
//  - Write enable = valid & rt_flag & (rt!=0) & state==RUN. Register 0 is never written.
//  - Collision: both slots enabled with u_rt==l_rt -> lower slot wins, u_we forced 0 (program order: lower is younger).
//  - Latency: inputs at edge N -> write ports valid after edge N+1 (one register stage).
//    Fwd outputs are combinational in cycle N.
//  - FSM: RUN -> HALTED when either valid slot has OP_HALT. The other slot of that same bundle still retires
//    (lower slot only if halt is in upper). HALTED is sticky until rstn; in HALTED all we=0 and fwd we=0.
//  - Reset mid-operation: outputs drop at once (async); the first bundle after release is treated as new.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: retire_cnt port present; +0/+1/+2 per cycle by retiring valid slots.
//    HALT slot counts; wraps modulo 2^CNT_W; frozen in HALTED.
//  Not defined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  core_pkg: OP_LOAD, OP_STORE(6'b010001), OP_HALT, BUBBLE_SLOT constant, wb_state_t enum {RUN,HALTED}.
//  Sub-module wb_lane (instantiated twice): slot valid decode, data select, enable gen.
//  Collision, FSM and counter live in write_back.
// TESTING
//  1 lower ALU op l_rt=5 l_tdata=-7, flag=1 -> next cycle l_we=1 l_waddr=5 l_wdata=32'hFFFFFFF9; u_we=0.
//  2 both slots OP_LOAD rt 3/4, mem_doutb=64'hAAAA0000_0000BBBB -> u_wdata=AAAA0000, l_wdata=0000BBBB.
//  3 both slots rt=9 flags=1 -> only l_we=1 addr 9; rt=0 with flag=1 -> no write.
//  4 bubble bundle {3'b111,29'b0}x2 with flags forced 1 -> no writes, retire_cnt unchanged.
//  5 upper OP_HALT, lower ALU rt=2 -> lower writes, halted=1 next cycle; later bundles never write;
//    rstn pulse mid-stream clears halted and outputs at once.
//  6 WB_RETIRE_CNT_EN, CNT_W=4: 9 cycles of two valid slots -> retire_cnt = 18 mod 16 = 2.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the write-back stage: opcodes, bubble encoding,
// FSM state type and the register-file write payload.
package core_pkg;

  localparam int unsigned SLOT_W = 32;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPC_W  = 6;

  localparam logic [OPC_W-1:0]  OP_LOAD     = 6'b010000;
  localparam logic [OPC_W-1:0]  OP_STORE    = 6'b010001;
  localparam logic [OPC_W-1:0]  OP_HALT     = 6'b111111;
  localparam logic [SLOT_W-1:0] BUBBLE_SLOT = {3'b111, 29'b0};

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

  // One register-file write port
  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_port_t;

  // A slot carries work unless it is exactly the bubble pattern
  function automatic logic slot_valid(input logic [SLOT_W-1:0] slot);
    return slot != BUBBLE_SLOT;
  endfunction

endpackage

// File: rtl/wb_lane.sv
// One write-back slot: valid decode, halt detect, write-data select and
// write-enable generation. Purely combinational.
// Ports:
//   i_slot      slot instruction word
//   i_mem_data  BRAM half aligned with this slot (used on loads)
//   i_alt_data  data used when the slot is not a load
//   i_rt        destination register
//   i_rt_flag   slot writes a register
//   i_run       stage is in RUN state
//   o_valid_c   slot is not a bubble
//   o_halt_c    slot is a valid HALT
//   o_wr_c      selected write (before collision resolution)
module wb_lane
  import core_pkg::*;
(
  input  logic [SLOT_W-1:0] i_slot,
  input  logic [XLEN-1:0]   i_mem_data,
  input  logic [XLEN-1:0]   i_alt_data,
  input  logic [REG_AW-1:0] i_rt,
  input  logic              i_rt_flag,
  input  logic              i_run,
  output logic              o_valid_c,
  output logic              o_halt_c,
  output wb_port_t          o_wr_c
);

  logic [OPC_W-1:0] w_opcode;
  logic             w_is_load;

  // Decode and select; register 0 is never a write target
  always_comb begin
    w_opcode    = i_slot[SLOT_W-1 -: OPC_W];
    w_is_load   = (w_opcode == OP_LOAD);
    o_valid_c   = slot_valid(i_slot);
    o_halt_c    = o_valid_c & (w_opcode == OP_HALT);
    o_wr_c.we   = o_valid_c & i_rt_flag & (i_rt != '0) & i_run;
    o_wr_c.addr = i_rt;
    o_wr_c.data = w_is_load ? i_mem_data : i_alt_data;
  end

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: selects per-slot write data, resolves same-register
// collisions (lower slot is younger and wins), registers the two register-file
// write ports, exposes combinational bypass copies and owns the HALT FSM.
// Optional macro WB_RETIRE_CNT_EN adds parameter CNT_W and port retire_cnt.
// Ports:
//   clk, rstn                   clock, async active-low reset
//   inst[63:0]                  dual-slot bundle (upper [63:32], lower [31:0])
//   u_rt, u_rt_flag             upper destination / write flag
//   l_tdata, l_rt, l_rt_flag    lower ALU result / destination / write flag
//   mem_doutb[63:0]             BRAM read data aligned with inst
//   u_we/u_waddr/u_wdata        registered upper write port
//   l_we/l_waddr/l_wdata        registered lower write port
//   fwd_u_*/fwd_l_*             combinational bypass of this cycle's writes
//   halted                      core stopped
//   retire_cnt                  retired non-bubble slots (WB_RETIRE_CNT_EN)
module write_back
  import core_pkg::*;
`ifdef WB_RETIRE_CNT_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [63:0]       inst,
  input  logic [REG_AW-1:0] u_rt,
  input  logic              u_rt_flag,
  input  logic [XLEN-1:0]   l_tdata,
  input  logic [REG_AW-1:0] l_rt,
  input  logic              l_rt_flag,
  input  logic [63:0]       mem_doutb,
  output logic              u_we,
  output logic [REG_AW-1:0] u_waddr,
  output logic [XLEN-1:0]   u_wdata,
  output logic              l_we,
  output logic [REG_AW-1:0] l_waddr,
  output logic [XLEN-1:0]   l_wdata,
  output logic              fwd_u_we,
  output logic [REG_AW-1:0] fwd_u_waddr,
  output logic [XLEN-1:0]   fwd_u_wdata,
  output logic              fwd_l_we,
  output logic [REG_AW-1:0] fwd_l_waddr,
  output logic [XLEN-1:0]   fwd_l_wdata,
  output logic              halted
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt
`endif
);

  wb_state_t r_state;
  wb_state_t w_next_state;
  logic      w_run;
  logic      w_u_valid, w_l_valid;
  logic      w_u_halt, w_l_halt;
  wb_port_t  w_u_wr, w_l_wr;
  logic      w_collide;

  assign w_run = (r_state == RUN);

  // Upper slot has no ALU path: its non-load data is its own BRAM half
  wb_lane u_lane_upper (
    .i_slot     (inst[63:32]),
    .i_mem_data (mem_doutb[63:32]),
    .i_alt_data (mem_doutb[63:32]),
    .i_rt       (u_rt),
    .i_rt_flag  (u_rt_flag),
    .i_run      (w_run),
    .o_valid_c  (w_u_valid),
    .o_halt_c   (w_u_halt),
    .o_wr_c     (w_u_wr)
  );

  wb_lane u_lane_lower (
    .i_slot     (inst[31:0]),
    .i_mem_data (mem_doutb[31:0]),
    .i_alt_data (l_tdata),
    .i_rt       (l_rt),
    .i_rt_flag  (l_rt_flag),
    .i_run      (w_run),
    .o_valid_c  (w_l_valid),
    .o_halt_c   (w_l_halt),
    .o_wr_c     (w_l_wr)
  );

  // Same destination in both slots: the younger lower write survives
  assign w_collide   = w_u_wr.we & w_l_wr.we & (w_u_wr.addr == w_l_wr.addr);

  assign fwd_u_we    = w_u_wr.we & ~w_collide;
  assign fwd_u_waddr = w_u_wr.addr;
  assign fwd_u_wdata = w_u_wr.data;
  assign fwd_l_we    = w_l_wr.we;
  assign fwd_l_waddr = w_l_wr.addr;
  assign fwd_l_wdata = w_l_wr.data;

  // HALT FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // HALT FSM next state; HALTED is left only through reset
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:     if (w_u_halt | w_l_halt) w_next_state = HALTED;
      HALTED:  w_next_state = HALTED;
      default: w_next_state = RUN;
    endcase
  end

  // Registered register-file write ports
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      u_we    <= 1'b0;
      u_waddr <= '0;
      u_wdata <= '0;
      l_we    <= 1'b0;
      l_waddr <= '0;
      l_wdata <= '0;
      halted  <= 1'b0;
    end else begin
      u_we    <= fwd_u_we;
      u_waddr <= fwd_u_waddr;
      u_wdata <= fwd_u_wdata;
      l_we    <= fwd_l_we;
      l_waddr <= fwd_l_waddr;
      l_wdata <= fwd_l_wdata;
      halted  <= (w_next_state == HALTED);
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic w_retire_u, w_retire_l;

  // A slot retires when valid while running; HALT itself counts
  assign w_retire_u = w_u_valid & w_run;
  assign w_retire_l = w_l_valid & w_run;

  // Retire counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_cnt <= '0;
    end else begin
      retire_cnt <= retire_cnt + CNT_W'(w_retire_u) + CNT_W'(w_retire_l);
    end
  end
`else
  logic w_unused_valid;
  assign w_unused_valid = w_u_valid ^ w_l_valid;
`endif

endmodule

// File: tb/tb_write_back.sv
module tb_write_back;

  localparam logic [5:0]  T_LOAD  = 6'b010000;
  localparam logic [5:0]  T_STORE = 6'b010001;
  localparam logic [5:0]  T_HALT  = 6'b111111;
  localparam logic [31:0] T_BUB   = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] inst;
  logic [4:0]  u_rt, l_rt;
  logic        u_rt_flag, l_rt_flag;
  logic [31:0] l_tdata;
  logic [63:0] mem_doutb;
  logic        u_we, l_we, fwd_u_we, fwd_l_we, halted;
  logic [4:0]  u_waddr, l_waddr, fwd_u_waddr, fwd_l_waddr;
  logic [31:0] u_wdata, l_wdata, fwd_u_wdata, fwd_l_wdata;
`ifdef WB_RETIRE_CNT_EN
  logic [3:0]  retire_cnt;
`endif

  always #5 clk = ~clk;

`ifdef WB_RETIRE_CNT_EN
  write_back #(.CNT_W(4)) dut (
`else
  write_back dut (
`endif
    .clk(clk), .rstn(rstn), .inst(inst),
    .u_rt(u_rt), .u_rt_flag(u_rt_flag),
    .l_tdata(l_tdata), .l_rt(l_rt), .l_rt_flag(l_rt_flag),
    .mem_doutb(mem_doutb),
    .u_we(u_we), .u_waddr(u_waddr), .u_wdata(u_wdata),
    .l_we(l_we), .l_waddr(l_waddr), .l_wdata(l_wdata),
    .fwd_u_we(fwd_u_we), .fwd_u_waddr(fwd_u_waddr), .fwd_u_wdata(fwd_u_wdata),
    .fwd_l_we(fwd_l_we), .fwd_l_waddr(fwd_l_waddr), .fwd_l_wdata(fwd_l_wdata),
    .halted(halted)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  typedef struct {
    logic        uwe;
    logic [4:0]  ua;
    logic [31:0] ud;
    logic        lwe;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        halted;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_halted = 1'b0;
  logic [3:0]  m_cnt = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural rules applied to one bundle
  task automatic model(output exp_t e);
    logic [31:0] us, ls;
    logic        uv, lv, uh, lh;
    us = inst[63:32];
    ls = inst[31:0];
    uv = (us != T_BUB);
    lv = (ls != T_BUB);
    uh = uv && (us[31:26] == T_HALT);
    lh = lv && (ls[31:26] == T_HALT);
    e.uwe = !m_halted && uv && u_rt_flag && (u_rt != 5'd0);
    e.lwe = !m_halted && lv && l_rt_flag && (l_rt != 5'd0);
    if (e.uwe && e.lwe && (u_rt == l_rt)) e.uwe = 1'b0;
    e.ua = u_rt;
    e.ud = mem_doutb[63:32];
    e.la = l_rt;
    e.ld = (ls[31:26] == T_LOAD) ? mem_doutb[31:0] : l_tdata;
    if (!m_halted) begin
      m_cnt = m_cnt + 4'(int'(uv) + int'(lv));
      if (uh || lh) m_halted = 1'b1;
    end
    e.halted = m_halted;
    e.cnt    = m_cnt;
  endtask

  // Drive one bundle, check bypass outputs, queue the registered expectation
  task automatic send(input logic [63:0] b, input logic [4:0] ur, input logic uf,
                      input logic [4:0] lr, input logic lf, input logic [31:0] td,
                      input logic [63:0] md);
    exp_t e;
    @(negedge clk);
    inst = b; u_rt = ur; u_rt_flag = uf; l_rt = lr; l_rt_flag = lf;
    l_tdata = td; mem_doutb = md;
    #1;
    model(e);
    chk("fwd_u_we", 32'(fwd_u_we), 32'(e.uwe));
    chk("fwd_l_we", 32'(fwd_l_we), 32'(e.lwe));
    if (e.uwe) begin
      chk("fwd_u_waddr", 32'(fwd_u_waddr), 32'(e.ua));
      chk("fwd_u_wdata", fwd_u_wdata, e.ud);
    end
    if (e.lwe) begin
      chk("fwd_l_waddr", 32'(fwd_l_waddr), 32'(e.la));
      chk("fwd_l_wdata", fwd_l_wdata, e.ld);
    end
    exp_q.push_back(e);
  endtask

  task automatic send_bubble();
    send({T_BUB, T_BUB}, 5'd1, 1'b1, 5'd2, 1'b1, 32'h0, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_u_we", 32'(u_we), 32'd0);
    chk("rst_l_we", 32'(l_we), 32'd0);
    chk("rst_u_waddr", 32'(u_waddr), 32'd0);
    chk("rst_l_wdata", l_wdata, 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
`endif
    exp_q.delete();
    m_halted = 1'b0;
    m_cnt = 4'd0;
    inst = {T_BUB, T_BUB}; u_rt_flag = 1'b0; l_rt_flag = 1'b0;
    @(negedge clk);
    #3;
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] rnd_slot(input bit allow_halt);
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       return T_BUB;
      1:       return 32'hE000_0001;
      2, 3:    return {T_LOAD, 26'($urandom)};
      4:       return {T_STORE, 26'($urandom)};
      5:       return allow_halt ? {T_HALT, 26'($urandom)} : {6'h03, 26'($urandom)};
      default: return {6'($urandom_range(0, 15)), 26'($urandom)};
    endcase
  endfunction

  task automatic send_random(input bit allow_halt);
    send({rnd_slot(allow_halt), rnd_slot(allow_halt)},
         5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
         $urandom, {$urandom, $urandom});
  endtask

  // Monitor: one expectation per cycle for the registered write ports
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("u_we", 32'(u_we), 32'(e.uwe));
      chk("l_we", 32'(l_we), 32'(e.lwe));
      chk("halted", 32'(halted), 32'(e.halted));
      if (e.uwe) begin
        chk("u_waddr", 32'(u_waddr), 32'(e.ua));
        chk("u_wdata", u_wdata, e.ud);
      end
      if (e.lwe) begin
        chk("l_waddr", 32'(l_waddr), 32'(e.la));
        chk("l_wdata", l_wdata, e.ld);
      end
`ifdef WB_RETIRE_CNT_EN
      chk("retire_cnt", 32'(retire_cnt), 32'(e.cnt));
`endif
    end
  end

  initial begin
    inst = {T_BUB, T_BUB}; u_rt = 5'd0; l_rt = 5'd0; u_rt_flag = 1'b0; l_rt_flag = 1'b0;
    l_tdata = 32'h0; mem_doutb = 64'h0;
    #12;
    chk("init_u_we", 32'(u_we), 32'd0);
    chk("init_l_we", 32'(l_we), 32'd0);
    chk("init_halted", 32'(halted), 32'd0);
    chk("init_l_waddr", 32'(l_waddr), 32'd0);
    @(negedge clk);
    #3;
    rstn = 1'b1;

    // Lower ALU op writes -7 to r5
    send({T_BUB, 6'h01, 26'h5}, 5'd0, 1'b0, 5'd5, 1'b1, 32'hFFFF_FFF9, 64'h0);
    send_bubble();
    chk("t1_l_we", 32'(l_we), 32'd1);
    chk("t1_l_waddr", 32'(l_waddr), 32'd5);
    chk("t1_l_wdata", l_wdata, 32'hFFFF_FFF9);
    chk("t1_u_we", 32'(u_we), 32'd0);

    // Both slots load
    send({T_LOAD, 26'h1, T_LOAD, 26'h2}, 5'd3, 1'b1, 5'd4, 1'b1, 32'h1234_5678,
         64'hAAAA0000_0000BBBB);
    send_bubble();
    chk("t2_u_wdata", u_wdata, 32'hAAAA_0000);
    chk("t2_l_wdata", l_wdata, 32'h0000_BBBB);
    chk("t2_u_we", 32'(u_we), 32'd1);

    // Collision on r9, then writes to r0
    send({6'h02, 26'h7, 6'h03, 26'h9}, 5'd9, 1'b1, 5'd9, 1'b1, 32'h55, 64'h1);
    send({6'h02, 26'h7, 6'h03, 26'h9}, 5'd0, 1'b1, 5'd0, 1'b1, 32'h66, 64'h2);
    chk("t3_u_we", 32'(u_we), 32'd0);
    chk("t3_l_we", 32'(l_we), 32'd1);
    chk("t3_l_waddr", 32'(l_waddr), 32'd9);
    send_bubble();
    chk("t3_r0_u_we", 32'(u_we), 32'd0);
    chk("t3_r0_l_we", 32'(l_we), 32'd0);

    // Bubbles with flags set
    send({T_BUB, T_BUB}, 5'd7, 1'b1, 5'd6, 1'b1, 32'h77, 64'h3);
    send_bubble();
    chk("t4_u_we", 32'(u_we), 32'd0);
    chk("t4_l_we", 32'(l_we), 32'd0);

    // Randomized run without halts
    for (int i = 0; i < 300; i++) send_random(1'b0);

    // Upper halt, lower still writes; later bundles never write
    send({T_HALT, 26'h0, 6'h01, 26'h5}, 5'd1, 1'b0, 5'd2, 1'b1, 32'h1234, 64'h0);
    send_bubble();
    chk("t5_l_we", 32'(l_we), 32'd1);
    chk("t5_l_waddr", 32'(l_waddr), 32'd2);
    chk("t5_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++)
      send({6'h01, 26'h1, 6'h02, 26'h2}, 5'd3, 1'b1, 5'd4, 1'b1, 32'h9, 64'h8);
    send_bubble();
    chk("t5_post_u_we", 32'(u_we), 32'd0);
    chk("t5_post_l_we", 32'(l_we), 32'd0);
    chk("t5_post_halted", 32'(halted), 32'd1);
    do_reset();

    // Randomized run with halts and periodic resets
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 25; i++) send_random(1'b1);
      do_reset();
    end

    // Nine cycles of two valid slots
    for (int i = 0; i < 9; i++)
      send({6'h01, 26'h1, 6'h02, 26'h2}, 5'd1, 1'b1, 5'd2, 1'b1, 32'($urandom), 64'h0);
    send_bubble();
    chk("t6_l_we", 32'(l_we), 32'd1);
`ifdef WB_RETIRE_CNT_EN
    chk("t6_retire_cnt", 32'(retire_cnt), 32'd2);
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
